// File: rtl/apb_slave_router_if.sv
// Requester handshake plus per-slave request/response bundle for apb_slave_router.
// The slave modport is the router side; the master modport is the requester/slave-model side.
interface apb_slave_router_if #(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DW      = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [DW-1:0]           din_a;
  logic [DW-1:0]           din_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           dout;
  logic                    error;
  logic [NUM_SLV-1:0]      s_valid;
  logic [NUM_SLV-1:0]      s_ready;
  logic [NUM_SLV*DW-1:0]   s_din_a;
  logic [NUM_SLV*DW-1:0]   s_din_b;
  logic [NUM_SLV-1:0]      s_rvalid;
  logic [NUM_SLV-1:0]      s_rready;
  logic [NUM_SLV*DW-1:0]   s_dout;
  logic [NUM_SLV-1:0]      s_error;

  modport slave (
    input  in_valid, sel, din_a, din_b, out_ready,
    input  s_ready, s_rvalid, s_dout, s_error,
    output in_ready, out_valid, dout, error,
    output s_valid, s_din_a, s_din_b, s_rready
  );

  modport master (
    output in_valid, sel, din_a, din_b, out_ready,
    output s_ready, s_rvalid, s_dout, s_error,
    input  in_ready, out_valid, dout, error,
    input  s_valid, s_din_a, s_din_b, s_rready
  );
endinterface

// File: rtl/apb_slave_router.sv
// Routes one request at a time to one of NUM_SLV slaves and returns its response.
// Optional watchdog abort of hung slaves is enabled by defining ROUTER_TIMEOUT_EN.
module apb_slave_router #(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  apb_slave_router_if.slave bus
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || (2 ** SEL_W) < NUM_SLV || TIMEOUT < 1) begin : g_cfg_err
    $error("apb_slave_router: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      b_q;
  logic [DW-1:0]      dout_q;
  logic               error_q;

  logic [NUM_SLV-1:0] hit;
  logic               req_done;
  logic               rsp_done;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;

`ifdef ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt;
  logic               expired;
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`endif

  // One-hot decode of the latched target; all-zero for an out-of-range select.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      hit[i] = (sel_q == SEL_W'(i));
    end
  end

  assign req_done = |(bus.s_ready & hit);
  assign rsp_done = |(bus.s_rvalid & hit);

  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (hit[i]) begin
        rsp_data = bus.s_dout[i*DW +: DW];
        rsp_err  = bus.s_error[i];
      end
    end
  end

  // Slave-side outputs decoded from the state and latched request only.
  always_comb begin
    bus.s_valid  = '0;
    bus.s_rready = '0;
    bus.s_din_a  = '0;
    bus.s_din_b  = '0;
    if (state == REQ) begin
      bus.s_valid = hit;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
        if (hit[i]) begin
          bus.s_din_a[i*DW +: DW] = a_q;
          bus.s_din_b[i*DW +: DW] = b_q;
        end
      end
    end
    if (state == RESP) begin
      bus.s_rready = hit;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.dout      = dout_q;
  assign bus.error     = error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      error_q <= 1'b0;
`ifdef ROUTER_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sel_q <= bus.sel;
            a_q   <= bus.din_a;
            b_q   <= bus.din_b;
            if (32'(bus.sel) < NUM_SLV) begin
              state <= REQ;
`ifdef ROUTER_TIMEOUT_EN
              cnt   <= '0;
`endif
            end else begin
              state   <= OUT;
              dout_q  <= '0;
              error_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (req_done) begin
            state <= RESP;
          end
`ifdef ROUTER_TIMEOUT_EN
          else if (expired) begin
            state   <= OUT;
            dout_q  <= '0;
            error_q <= 1'b1;
          end
          cnt <= cnt + CNT_W'(1);
`endif
        end
        RESP: begin
          if (rsp_done) begin
            state   <= OUT;
            dout_q  <= rsp_data;
            error_q <= rsp_err;
          end
`ifdef ROUTER_TIMEOUT_EN
          else if (expired) begin
            state   <= OUT;
            dout_q  <= '0;
            error_q <= 1'b1;
          end
          cnt <= cnt + CNT_W'(1);
`endif
        end
        OUT: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_router.sv
// Randomized self-checking bench for apb_slave_router (NUM_SLV=3, SEL_W=2, DW=32).
// Expected responses come from the routing rules: valid select returns the slave reply, else error.
module tb_apb_slave_router;
  localparam int unsigned NUM_SLV = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned VW      = NUM_SLV * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  apb_slave_router_if #(.NUM_SLV(NUM_SLV), .SEL_W(SEL_W), .DW(DW)) bus ();

  apb_slave_router #(
    .NUM_SLV(NUM_SLV), .SEL_W(SEL_W), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_SLV-1:0] onehot(input int s);
    onehot = '0;
    if (s < int'(NUM_SLV)) onehot[s] = 1'b1;
  endfunction

  function automatic logic [VW-1:0] place(input int s, input logic [DW-1:0] v);
    place = '0;
    if (s < int'(NUM_SLV)) place[s*DW +: DW] = v;
  endfunction

  // Random activity on other slaves, with the targeted slave's bit forced.
  function automatic logic [NUM_SLV-1:0] noise(input int s, input logic b);
    logic [NUM_SLV-1:0] v;
    v = NUM_SLV'($urandom);
    v[s] = b;
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return VW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic clear_slaves();
    bus.s_ready  = '0;
    bus.s_rvalid = '0;
    bus.s_error  = '0;
    bus.s_dout   = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_s_valid"},   128'(bus.s_valid),   128'(0));
    chk({tag, "_s_rready"},  128'(bus.s_rready),  128'(0));
  endtask

  task automatic accept(input int s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_in_ready", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.sel      = SEL_W'(s);
    bus.din_a    = a;
    bus.din_b    = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sel      = SEL_W'($urandom);
    bus.din_a    = $urandom;
    bus.din_b    = $urandom;
  endtask

  // One full transaction with given slave/requester delays.
  task automatic txn(input int s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input int rdly, input int vdly, input int odly,
                     input logic [DW-1:0] rdata, input logic rerr);
    bit            routed;
    logic [DW-1:0] exp_d;
    logic          exp_e;
    routed = (s < int'(NUM_SLV));
    exp_d  = routed ? rdata : '0;
    exp_e  = routed ? rerr : 1'b1;
    accept(s, a, b);
    if (routed) begin
      for (int d = 0; d <= rdly; d++) begin
        chk("req_s_valid",   128'(bus.s_valid),   128'(onehot(s)));
        chk("req_s_din_a",   128'(bus.s_din_a),   128'(place(s, a)));
        chk("req_s_din_b",   128'(bus.s_din_b),   128'(place(s, b)));
        chk("req_s_rready",  128'(bus.s_rready),  128'(0));
        chk("req_in_ready",  128'(bus.in_ready),  128'(0));
        chk("req_out_valid", 128'(bus.out_valid), 128'(0));
        bus.s_ready  = noise(s, d == rdly);
        bus.s_rvalid = noise(s, 1'b0);
        bus.s_dout   = rand_vec();
        @(negedge clk);
      end
      for (int d = 0; d <= vdly; d++) begin
        chk("rsp_s_rready",  128'(bus.s_rready),  128'(onehot(s)));
        chk("rsp_s_valid",   128'(bus.s_valid),   128'(0));
        chk("rsp_out_valid", 128'(bus.out_valid), 128'(0));
        bus.s_ready  = NUM_SLV'($urandom);
        bus.s_rvalid = noise(s, d == vdly);
        bus.s_error  = noise(s, (d == vdly) ? rerr : 1'b0);
        bus.s_dout   = rand_vec();
        if (d == vdly) bus.s_dout[s*DW +: DW] = rdata;
        @(negedge clk);
      end
    end
    for (int d = 0; d <= odly; d++) begin
      chk("out_valid",     128'(bus.out_valid), 128'(1));
      chk("out_dout",      128'(bus.dout),      128'(exp_d));
      chk("out_error",     128'(bus.error),     128'(exp_e));
      chk("out_in_ready",  128'(bus.in_ready),  128'(0));
      chk("out_s_valid",   128'(bus.s_valid),   128'(0));
      chk("out_s_rready",  128'(bus.s_rready),  128'(0));
      bus.out_ready = (d == odly);
      bus.in_valid  = 1'($urandom);
      bus.sel       = SEL_W'($urandom);
      bus.s_rvalid  = NUM_SLV'($urandom);
      bus.s_dout    = rand_vec();
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    clear_slaves();
    check_idle("post");
  endtask

  task automatic reset_mid_op();
    accept(1, 32'hAAAA_0001, 32'hBBBB_0001);
    bus.s_ready = onehot(1);
    @(negedge clk);
    bus.s_ready = '0;
    chk("rst_pre_s_rready", 128'(bus.s_rready), 128'(onehot(1)));
    bus.s_rvalid = onehot(1);
    bus.s_error  = onehot(1);
    bus.s_dout   = place(1, 32'hBEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_slaves();
    check_idle("rst_mid");
    chk("rst_mid_dout",  128'(bus.dout),    128'(0));
    chk("rst_mid_error", 128'(bus.error),   128'(0));
    chk("rst_mid_din_a", 128'(bus.s_din_a), 128'(0));
    chk("rst_mid_din_b", 128'(bus.s_din_b), 128'(0));
    @(negedge clk);
    check_idle("rst_stale");
  endtask

`ifdef ROUTER_TIMEOUT_EN
  task automatic timeout_test();
    accept(0, 32'h5, 32'h6);
    for (int d = 0; d < int'(TIMEOUT); d++) begin
      chk("to_s_valid",   128'(bus.s_valid),   128'(onehot(0)));
      chk("to_out_valid", 128'(bus.out_valid), 128'(0));
      bus.s_ready = noise(0, 1'b0);
      @(negedge clk);
    end
    bus.s_ready = '0;
    chk("to_abort_valid", 128'(bus.out_valid), 128'(1));
    chk("to_abort_dout",  128'(bus.dout),      128'(0));
    chk("to_abort_error", 128'(bus.error),     128'(1));
    chk("to_abort_sval",  128'(bus.s_valid),   128'(0));
    bus.s_rvalid = onehot(0);
    bus.s_dout   = place(0, 32'h1234);
    @(negedge clk);
    chk("to_late_dout",  128'(bus.dout),  128'(0));
    chk("to_late_error", 128'(bus.error), 128'(1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    clear_slaves();
    check_idle("to_after");
  endtask
`endif

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.din_a     = '0;
    bus.din_b     = '0;
    bus.out_ready = 1'b0;
    clear_slaves();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_dout",  128'(bus.dout),    128'(0));
    chk("reset_error", 128'(bus.error),   128'(0));
    chk("reset_din_a", 128'(bus.s_din_a), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    txn(2, 32'h11, 32'h22, 0, 0, 0, 32'h33, 1'b0);
    txn(3, 32'h44, 32'h55, 0, 0, 0, 32'h0, 1'b0);
    txn(0, 32'h66, 32'h77, 5, 0, 4, 32'h88, 1'b0);
    txn(1, 32'h99, 32'hAA, 0, 0, 0, 32'hDEAD, 1'b1);
    reset_mid_op();
`ifdef ROUTER_TIMEOUT_EN
    timeout_test();
`endif
    for (int n = 0; n < 40; n++) begin
      txn($urandom_range(0, 3), $urandom, $urandom,
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
          $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
